fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer_if.sv | 29 ++
 rtl/fetch_sequencer.sv | 101 ++++++++++
 tb/tb_fetch_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory, decode and
// branch resolution. The master modport is the sequencer's view.
interface fetch_sequencer_if #(
  parameter int Width = 32
) ();
  logic             imem_req;
  logic [Width-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [Width-1:0] imem_rdata;
  logic             inst_valid;
  logic             inst_ready;
  logic [Width-1:0] inst_out;
  logic [Width-1:0] inst_pc;
  logic             redirect_valid;
  logic [Width-1:0] redirect_target;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready,
           redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready,
           redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, requests words from instruction
// memory, buffers responses in a 2-entry queue and hands them to decode.
// Redirects flush the queue and discard responses still in flight.
//
//   state | meaning
//   RUN   | fetching; responses are queued toward decode
//   FLUSH | no requests; stale responses counted down and dropped
module fetch_sequencer #(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [Width-1:0] pc;
  logic [1:0]       outstanding, outstanding_nxt, occupancy;
  logic [Width-1:0] af_addr [2];
  logic [Width-1:0] q_data [2];
  logic [Width-1:0] q_pc [2];
  logic             req, accept, resp, push, pop, credit, af_idx, q_idx;

  // Outstanding + occupancy never exceeds 2, so a response always finds a
  // free queue slot and the write index collapses to a single bit.
  assign accept          = req & bus.imem_gnt;
  assign resp            = bus.imem_rvalid & (outstanding != 2'd0);
  assign pop             = (occupancy != 2'd0) & bus.inst_ready;
  assign push            = resp & (state == RUN) & ~bus.redirect_valid;
  assign credit          = ({1'b0, outstanding} + {1'b0, occupancy}) < 3'd2;
  assign outstanding_nxt = outstanding + {1'b0, accept} - {1'b0, resp};
  assign af_idx          = outstanding[0] & ~resp;
  assign q_idx           = occupancy[0] & ~pop;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = (occupancy != 2'd0);
  assign bus.inst_out   = q_data[0];
  assign bus.inst_pc    = q_pc[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state and request; a redirect overrides whatever the state wanted.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      RUN:     req = ~rst & ~bus.redirect_valid & credit;
      FLUSH:   if (outstanding_nxt == 2'd0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (bus.redirect_valid) state_nxt = (outstanding_nxt != 2'd0) ? FLUSH : RUN;
  end

  // PC and in-flight address tracking; in FLUSH the count is the discard count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      af_addr[0]  <= '0;
      af_addr[1]  <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_valid) pc <= {bus.redirect_target[Width-1:2], 2'b00};
      else if (accept)        pc <= pc + {{(Width-3){1'b0}}, 3'd4};
      if (resp)   af_addr[0]      <= af_addr[1];
      if (accept) af_addr[af_idx] <= pc;
    end
  end

  // Instruction queue toward decode; head always sits in slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= 2'd0;
      q_data[0] <= '0;
      q_data[1] <= '0;
      q_pc[0]   <= '0;
      q_pc[1]   <= '0;
    end else if (bus.redirect_valid) begin
      occupancy <= 2'd0;
    end else begin
      if (pop) begin
        q_data[0] <= q_data[1];
        q_pc[0]   <= q_pc[1];
      end
      if (push) begin
        q_data[q_idx] <= bus.imem_rdata;
        q_pc[q_idx]   <= af_addr[0];
      end
      occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a scoreboard of expected
// {pc, word} pairs checked by an independent monitor on each handshake.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.Width(32)) bus ();
  fetch_sequencer_if #(.Width(32)) bus2 ();

  fetch_sequencer #(.Width(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  fetch_sequencer #(.Width(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend[$];
  logic [31:0] pend2[$];
  logic [31:0] addr2_q[$];

  int          checks = 0;
  int          errors = 0;
  int          budget, acc_cnt, acc0;
  bit          ready_v, hold_v, spur_v, redir_v, rst_v, last_req;
  logic [31:0] tgt_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = pc ^ 32'hA5A5_0000;
    exp_q.push_back(e);
  endtask

  // One cycle: drive inputs on the falling edge, then log what the rising
  // edge will accept. Memory answers one cycle after an accepted request.
  task automatic step();
    @(negedge clk);
    rst = rst_v;
    if (rst_v) begin
      pend.delete();
      pend2.delete();
    end
    if (spur_v) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end else if (!hold_v && pend.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = pend.pop_front() ^ 32'hA5A5_0000;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
    bus.imem_gnt        = (budget > 0);
    bus.inst_ready      = ready_v;
    bus.redirect_valid  = redir_v;
    bus.redirect_target = tgt_v;
    if (pend2.size() > 0) begin
      bus2.imem_rvalid = 1'b1;
      bus2.imem_rdata  = pend2.pop_front();
    end else begin
      bus2.imem_rvalid = 1'b0;
      bus2.imem_rdata  = 32'h0;
    end
    #1;
    last_req = bus.imem_req;
    if (!rst_v && bus.imem_req && bus.imem_gnt) begin
      pend.push_back(bus.imem_addr);
      budget--;
      acc_cnt++;
    end
    if (!rst_v && bus2.imem_req) begin
      pend2.push_back(bus2.imem_addr);
      if (addr2_q.size() < 3) addr2_q.push_back(bus2.imem_addr);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string name, input int maxc);
    int c = 0;
    while ((exp_q.size() != 0 || pend.size() != 0) && c < maxc) begin
      step();
      c++;
    end
    check(name, 32'(c >= maxc), 32'd0);
  endtask

  // Monitor: every handshake must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.inst_valid && bus.inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst actual_pc=%h actual_word=%h expected=none",
                   bus.inst_pc, bus.inst_out);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", bus.inst_pc, e.pc);
          check("inst_out", bus.inst_out, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v = 1'b1; rst = 1'b1; budget = 0; acc_cnt = 0;
    ready_v = 1'b0; hold_v = 1'b0; spur_v = 1'b0; redir_v = 1'b0; tgt_v = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
    bus2.imem_gnt = 1'b1; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0;
    bus2.inst_ready = 1'b1; bus2.redirect_valid = 1'b0; bus2.redirect_target = 32'h0;

    run(3);
    check("rst_req", bus.imem_req, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", bus.inst_valid, 32'd0);
    check("rst_out", bus.inst_out, 32'h0);
    check("rst_pc", bus.inst_pc, 32'h0);

    // Streaming from reset.
    rst_v = 1'b0; ready_v = 1'b1; budget = 6;
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    step();
    check("first_req", last_req, 32'd1);
    drain("p1_drain", 40);

    check("wrap_cnt", addr2_q.size(), 32'd3);
    if (addr2_q.size() == 3) begin
      check("wrap_addr0", addr2_q[0], 32'hFFFF_FFF8);
      check("wrap_addr1", addr2_q[1], 32'hFFFF_FFFC);
      check("wrap_addr2", addr2_q[2], 32'h0000_0000);
    end

    // Decode stalls: only two credits, head held stable.
    ready_v = 1'b0; budget = 2; acc0 = acc_cnt;
    expect_pc(32'h18); expect_pc(32'h1C); expect_pc(32'h20); expect_pc(32'h24);
    run(3);
    check("stall_pc_early", bus.inst_pc, 32'h18);
    run(7);
    check("stall_accepts", 32'(acc_cnt - acc0), 32'd2);
    check("stall_req", bus.imem_req, 32'd0);
    check("stall_valid", bus.inst_valid, 32'd1);
    check("stall_pc", bus.inst_pc, 32'h18);
    budget = 2; ready_v = 1'b1;
    step();
    step();
    check("reissue_req", last_req, 32'd1);
    drain("p2_drain", 40);

    // Redirect with two requests in flight.
    hold_v = 1'b1; budget = 2;
    run(4);
    redir_v = 1'b1; tgt_v = 32'h0000_1003;
    step();
    redir_v = 1'b0;
    step();
    check("redir_addr", bus.imem_addr, 32'h0000_1000);
    check("flush_req", last_req, 32'd0);
    expect_pc(32'h1000); expect_pc(32'h1004);
    budget = 2; hold_v = 1'b0;
    drain("p3_drain", 40);

    // Two redirects while flushing; only the last target is fetched.
    hold_v = 1'b1; budget = 2;
    run(4);
    redir_v = 1'b1; tgt_v = 32'h0000_0100;
    step();
    redir_v = 1'b0; hold_v = 1'b0;
    step();
    hold_v = 1'b1; redir_v = 1'b1; tgt_v = 32'h0000_0200;
    step();
    redir_v = 1'b0;
    run(3);
    check("flush2_req", last_req, 32'd0);
    check("flush2_addr", bus.imem_addr, 32'h0000_0200);
    expect_pc(32'h200); expect_pc(32'h204);
    budget = 2; hold_v = 1'b0;
    drain("p4_drain", 40);

    // Spurious rvalid and grant without request on a full queue.
    ready_v = 1'b0; budget = 2;
    expect_pc(32'h208); expect_pc(32'h20C);
    run(6);
    check("full_valid", bus.inst_valid, 32'd1);
    check("full_pc", bus.inst_pc, 32'h208);
    budget = 5; spur_v = 1'b1;
    run(2);
    spur_v = 1'b0;
    step();
    check("spur_full_addr", bus.imem_addr, 32'h210);
    check("spur_full_pc", bus.inst_pc, 32'h208);
    check("gnt_noreq", budget, 32'd5);
    budget = 0; ready_v = 1'b1;
    drain("p5_drain", 40);
    run(2);
    spur_v = 1'b1;
    run(2);
    spur_v = 1'b0;
    step();
    check("spur_empty_valid", bus.inst_valid, 32'd0);
    check("spur_empty_addr", bus.imem_addr, 32'h210);

    // Reset mid-stream.
    ready_v = 1'b0; budget = 2;
    run(6);
    rst_v = 1'b1;
    step();
    step();
    check("mid_rst_req", last_req, 32'd0);
    check("mid_rst_addr", bus.imem_addr, 32'h0);
    check("mid_rst_valid", bus.inst_valid, 32'd0);
    check("mid_rst_out", bus.inst_out, 32'h0);
    check("mid_rst_pc", bus.inst_pc, 32'h0);
    exp_q.delete();
    rst_v = 1'b0; ready_v = 1'b1; budget = 1;
    expect_pc(32'h0);
    step();
    check("post_rst_req", last_req, 32'd1);
    drain("p6_drain", 40);
    run(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
